simon_sequencer: RTL and testbench

SIMON_SEQUENCER -- requirements
Module: simon_sequencer

---
 rtl/simon_pkg.sv | 51 +++++
 rtl/simon_lfsr.sv | 28 ++
 rtl/simon_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_simon_sequencer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simon_pkg.sv
// Shared types and helpers for the Simon sequencer: state encoding, LFSR taps, bit helpers.
// Latency: n/a (package only).
// Backpressure: n/a.
package simon_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXTEND,
        ST_SHOW,
        ST_GAP,
        ST_INPUT,
        ST_WIN,
        ST_LOSE
    } state_t;

    // Right-shifting Galois tap masks. Widths without a listed maximal
    // polynomial fall back to a plain rotation, which never reaches zero
    // from a non-zero state but has a short period.
    function automatic logic [31:0] lfsr_taps(input int width);
        logic [31:0] taps;
        case (width)
            2:       taps = 32'h0000_0003;
            3:       taps = 32'h0000_0006;
            4:       taps = 32'h0000_000C;
            5:       taps = 32'h0000_0014;
            6:       taps = 32'h0000_0030;
            7:       taps = 32'h0000_0060;
            8:       taps = 32'h0000_00B8;
            16:      taps = 32'h0000_B400;
            32:      taps = 32'h8020_0003;
            default: taps = 32'h1 << (width - 1);
        endcase
        return taps;
    endfunction

    // Ceiling log2, usable in constant expressions.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << r) < 64'(v)) r = r + 1;
        end
        return r;
    endfunction

    // Symbol index to button/LED mask (up to 16 colours).
    function automatic logic [15:0] onehot(input logic [3:0] sym);
        return 16'h1 << sym;
    endfunction

endpackage

// File: rtl/simon_lfsr.sv
// Free-running Galois LFSR used as the symbol source.
// Latency: advances one step every clock; reset loads SEED (zero seed becomes 1).
// Backpressure: none, never stalls.
module simon_lfsr
    import simon_pkg::*;
#(
    parameter int                LFSR_W = 16,
    parameter logic [LFSR_W-1:0] SEED   = 16'hACE1
) (
    input  logic              CLOCK_50,
    input  logic              RESET,
    output logic [LFSR_W-1:0] q
);

    localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(lfsr_taps(LFSR_W));
    localparam logic [LFSR_W-1:0] INIT = (SEED == '0) ? LFSR_W'(1) : SEED;

    logic [LFSR_W-1:0] q_q;

    // Shift right, folding the taps in when a one falls out of bit 0.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) q_q <= INIT;
        else       q_q <= q_q[0] ? ((q_q >> 1) ^ TAPS) : (q_q >> 1);
    end

    assign q = q_q;

endmodule

// File: rtl/simon_sequencer.sv
// Simon game controller: grows a random sequence, plays it on the LEDs and checks player presses.
// Latency: all outputs registered; a state change shows one cycle after the deciding edge.
// Backpressure: none; presses outside INPUT and starts while busy are dropped.
module simon_sequencer
    import simon_pkg::*;
#(
    parameter int                NUM_BTN        = 4,
    parameter int                MAX_LEN        = 16,
    parameter int                SHOW_CYCLES    = 10000000,
    parameter int                GAP_CYCLES     = 2500000,
    parameter int                TIMEOUT_CYCLES = 250000000,
    parameter int                LFSR_W         = 16,
    parameter logic [LFSR_W-1:0] SEED           = 16'hACE1
) (
    input  logic                         CLOCK_50,
    input  logic                         RESET,
    input  logic                         start,
    input  logic [NUM_BTN-1:0]           btn_pulse,
    output logic [NUM_BTN-1:0]           led,
    output logic [clog2(MAX_LEN+1)-1:0]  level,
    output logic                         busy,
    output logic                         your_turn,
    output logic                         win,
    output logic                         lose
);

    localparam int SYM_W   = (NUM_BTN > 2) ? clog2(NUM_BTN) : 1;
    localparam int LVL_W   = clog2(MAX_LEN + 1);
    localparam int IDX_W   = (MAX_LEN > 1) ? clog2(MAX_LEN) : 1;
    localparam int MAX_SG  = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
    localparam int MAX_CNT = (MAX_SG > TIMEOUT_CYCLES) ? MAX_SG : TIMEOUT_CYCLES;
    localparam int CNT_W   = clog2(MAX_CNT + 1);

    state_t             state_q, state_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               clr_seq;
    logic [SYM_W-1:0]   seq_q [MAX_LEN];
    logic [LFSR_W-1:0]  lfsr_q;

    logic [NUM_BTN-1:0] led_q, led_d;
    logic               busy_q, busy_d, turn_q, turn_d, win_q, win_d, lose_q, lose_d;

    logic [SYM_W-1:0]   show_sym;
    logic [15:0]        oh_show, oh_exp;
    logic [NUM_BTN-1:0] btn_exp;
    logic               bits_unused;

    simon_lfsr #(.LFSR_W(LFSR_W), .SEED(SEED)) u_lfsr (
        .CLOCK_50 (CLOCK_50),
        .RESET    (RESET),
        .q        (lfsr_q)
    );

    // Button mask the player must hit for the symbol currently awaited.
    assign oh_exp  = onehot(4'(seq_q[idx_q]));
    assign btn_exp = oh_exp[NUM_BTN-1:0];
    assign bits_unused = ^{oh_show, oh_exp, lfsr_q};

    // Sequence store: wiped when a game starts, appended once per EXTEND.
    always_ff @(posedge CLOCK_50) begin
        if (RESET || clr_seq) begin
            for (int i = 0; i < MAX_LEN; i++) seq_q[i] <= '0;
        end else if (state_q == ST_EXTEND) begin
            seq_q[level_q[IDX_W-1:0]] <= lfsr_q[SYM_W-1:0];
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            level_q <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            led_q   <= '0;
            busy_q  <= 1'b0;
            turn_q  <= 1'b0;
            win_q   <= 1'b0;
            lose_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            led_q   <= led_d;
            busy_q  <= busy_d;
            turn_q  <= turn_d;
            win_q   <= win_d;
            lose_q  <= lose_d;
        end
    end

    // Next-state: playback timing, press checking and round progression.
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        clr_seq = 1'b0;
        case (state_q)
            ST_IDLE, ST_WIN, ST_LOSE: begin
                if (start) begin
                    state_d = ST_EXTEND;
                    level_d = '0;
                    idx_d   = '0;
                    cnt_d   = '0;
                    clr_seq = 1'b1;
                end
            end
            ST_EXTEND: begin
                level_d = level_q + LVL_W'(1);
                idx_d   = '0;
                cnt_d   = '0;
                state_d = ST_SHOW;
            end
            ST_SHOW: begin
                if (cnt_q == CNT_W'(SHOW_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_GAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
                    cnt_d = '0;
                    if (LVL_W'(idx_q) < level_q - LVL_W'(1)) begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = ST_SHOW;
                    end else begin
                        idx_d   = '0;
                        state_d = ST_INPUT;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_INPUT: begin
                if (btn_pulse == '0) begin
                    if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) state_d = ST_LOSE;
                    else                                    cnt_d   = cnt_q + CNT_W'(1);
                end else if (btn_pulse == btn_exp) begin
                    // btn_exp is one-hot, so equality also rules out multi-press.
                    cnt_d = '0;
                    if (LVL_W'(idx_q) == level_q - LVL_W'(1)) begin
                        idx_d   = '0;
                        state_d = (level_q == LVL_W'(MAX_LEN)) ? ST_WIN : ST_EXTEND;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    state_d = ST_LOSE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from next state so the registered copies line up with state_q.
    always_comb begin
        show_sym = seq_q[idx_d];
        // The symbol being stored this cycle is not in the array yet.
        if (state_q == ST_EXTEND && LVL_W'(idx_d) == level_q) show_sym = lfsr_q[SYM_W-1:0];
        oh_show = onehot(4'(show_sym));
        led_d   = (state_d == ST_SHOW) ? oh_show[NUM_BTN-1:0] : '0;
        busy_d  = !(state_d == ST_IDLE || state_d == ST_WIN || state_d == ST_LOSE);
        turn_d  = (state_d == ST_INPUT);
        win_d   = (state_d == ST_WIN);
        lose_d  = (state_d == ST_LOSE);
    end

    assign led       = led_q;
    assign level     = level_q;
    assign busy      = busy_q;
    assign your_turn = turn_q;
    assign win       = win_q;
    assign lose      = lose_q;

endmodule

// File: tb/tb_simon_sequencer.sv
// Scoreboard bench for simon_sequencer with short playback/timeout parameters.
// Stimulus pushes expected events; a monitor turns output activity into events and compares.
// Symbols are predicted from an independent LFSR model stepped alongside the DUT.
module tb_simon_sequencer;

    localparam int          NB   = 4;
    localparam int          ML   = 3;
    localparam int          SC   = 4;
    localparam int          GC   = 2;
    localparam int          TC   = 20;
    localparam logic [15:0] SEED = 16'hACE1;

    localparam int EV_SHOW = 0, EV_GAP = 1, EV_TURN = 2, EV_WIN = 3, EV_LOSE = 4;

    typedef struct {
        int kind;
        int val;
        int lvl;
        int len;
    } ev_t;

    logic          CLOCK_50 = 1'b0;
    logic          RESET    = 1'b1;
    logic          start    = 1'b0;
    logic [NB-1:0] btn_pulse = '0;
    logic [NB-1:0] led;
    logic [1:0]    level;
    logic          busy, your_turn, win, lose;

    int          total = 0;
    int          bad   = 0;
    ev_t         expq[$];
    logic [15:0] model;
    int          seq[ML];
    int          cur_len = 0;

    simon_sequencer #(
        .NUM_BTN(NB), .MAX_LEN(ML), .SHOW_CYCLES(SC), .GAP_CYCLES(GC),
        .TIMEOUT_CYCLES(TC), .LFSR_W(16), .SEED(SEED)
    ) dut (
        .CLOCK_50(CLOCK_50), .RESET(RESET), .start(start), .btn_pulse(btn_pulse),
        .led(led), .level(level), .busy(busy), .your_turn(your_turn),
        .win(win), .lose(lose)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Reference LFSR: x^16+x^14+x^13+x^11+1, right-shifting Galois form.
    always @(posedge CLOCK_50) begin
        if (RESET) model = SEED;
        else       model = {1'b0, model[15:1]} ^ (model[0] ? 16'hB400 : 16'h0000);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic push(input int k, input int v, input int l, input int n);
        ev_t e;
        e.kind = k; e.val = v; e.lvl = l; e.len = n;
        expq.push_back(e);
    endtask

    task automatic observe(input int k, input int v, input int l, input int n);
        ev_t e;
        total++;
        if (expq.size() == 0) begin
            bad++;
            $display("FAIL unexpected event: got kind=%0d val=%0d lvl=%0d len=%0d", k, v, l, n);
            return;
        end
        e = expq.pop_front();
        if (e.kind != k || e.val != v || e.lvl != l || (e.len >= 0 && e.len != n)) begin
            bad++;
            $display("FAIL event: got kind=%0d val=%0d lvl=%0d len=%0d want kind=%0d val=%0d lvl=%0d len=%0d",
                     k, v, l, n, e.kind, e.val, e.lvl, e.len);
        end
    endtask

    // Monitor: lit runs, dark gaps, and rising edges of your_turn/win/lose.
    logic [NB-1:0] prev_led;
    int            run_len, gap_len, turn_len;
    bit            gap_act, prev_turn, prev_win, prev_lose;

    always @(posedge CLOCK_50) begin
        #1;
        if (RESET) begin
            prev_led = '0; run_len = 0; gap_len = 0; turn_len = 0;
            gap_act = 0; prev_turn = 0; prev_win = 0; prev_lose = 0;
        end else begin
            if (led != '0) begin
                if (prev_led == '0) begin
                    if (gap_act) observe(EV_GAP, int'(busy), int'(level), gap_len);
                    gap_act = 0;
                    run_len = 1;
                end else begin
                    run_len++;
                end
            end else if (prev_led != '0) begin
                observe(EV_SHOW, int'(prev_led), int'(level), run_len);
                gap_act = 1;
                gap_len = 1;
            end else if (gap_act) begin
                if (your_turn || !busy) begin
                    observe(EV_GAP, int'(busy), int'(level), gap_len);
                    gap_act = 0;
                end else begin
                    gap_len++;
                end
            end
            if (your_turn && !prev_turn) begin
                observe(EV_TURN, int'(busy), int'(level), -1);
                turn_len = 1;
            end else if (your_turn) begin
                turn_len++;
            end
            if (win && !prev_win)   observe(EV_WIN, int'(busy), int'(level), -1);
            if (lose && !prev_lose) observe(EV_LOSE, int'(busy), int'(level), turn_len);
            prev_led = led; prev_turn = your_turn; prev_win = win; prev_lose = lose;
        end
    end

    task automatic push_playback();
        for (int i = 0; i < cur_len; i++) begin
            push(EV_SHOW, 1 << seq[i], cur_len, SC);
            push(EV_GAP, 1, cur_len, GC);
        end
        push(EV_TURN, 1, cur_len, -1);
    endtask

    // Pulse start; the following cycle is EXTEND, which latches the model's current value.
    task automatic do_start();
        start = 1'b1;
        @(negedge CLOCK_50);
        start = 1'b0;
        check("busy_in_extend", busy, 1);
        cur_len = 1;
        seq[0]  = int'(model[1:0]);
        push_playback();
    endtask

    task automatic wait_turn();
        int n;
        n = 0;
        while (!your_turn && n < 200) begin
            @(negedge CLOCK_50);
            n++;
        end
        check("wait_turn", your_turn, 1);
    endtask

    // Replay the whole sequence correctly; either extends or wins.
    task automatic press_round();
        for (int i = 0; i < cur_len; i++) begin
            if (i == cur_len - 1 && cur_len == ML) push(EV_WIN, 0, ML, -1);
            btn_pulse = NB'(1 << seq[i]);
            @(negedge CLOCK_50);
            btn_pulse = '0;
        end
        if (cur_len < ML) begin
            check("busy_extend", busy, 1);
            seq[cur_len] = int'(model[1:0]);
            cur_len++;
            push_playback();
        end else begin
            check("win_next", win, 1);
            check("busy_win", busy, 0);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int  n;
        bit  seen;
        RESET = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        check("rst_led", led, 0);
        check("rst_level", level, 0);
        check("rst_busy", busy, 0);
        check("rst_turn", your_turn, 0);
        check("rst_win", win, 0);
        check("rst_lose", lose, 0);
        check("rst_lfsr", dut.u_lfsr.q, SEED);
        RESET = 1'b0;
        @(negedge CLOCK_50);

        // Game A: three correct rounds, with a press injected during playback.
        do_start();
        wait_turn();
        press_round();
        repeat (2) @(negedge CLOCK_50);
        btn_pulse = 4'b1111;
        @(negedge CLOCK_50);
        btn_pulse = '0;
        wait_turn();
        press_round();
        wait_turn();
        press_round();
        repeat (5) @(negedge CLOCK_50);
        check("win_hold", win, 1);
        check("win_level", level, 3);

        // Game B: from WIN; round 2, second press wrong.
        do_start();
        wait_turn();
        press_round();
        wait_turn();
        btn_pulse = NB'(1 << seq[0]);
        @(negedge CLOCK_50);
        push(EV_LOSE, 0, 2, -1);
        btn_pulse = NB'(1 << ((seq[1] + 1) % NB));
        @(negedge CLOCK_50);
        btn_pulse = '0;
        check("lose_wrong", lose, 1);
        check("lose_level", level, 2);
        repeat (3) @(negedge CLOCK_50);
        check("lose_hold_level", level, 2);

        // Game C: from LOSE; no press until the timeout fires.
        do_start();
        wait_turn();
        push(EV_LOSE, 0, 1, TC);
        n = 0;
        while (!lose && n < 60) begin
            @(negedge CLOCK_50);
            n++;
        end
        check("lose_timeout", lose, 1);

        // Game D: two buttons at once in INPUT.
        do_start();
        wait_turn();
        press_round();
        wait_turn();
        push(EV_LOSE, 0, 2, -1);
        btn_pulse = NB'((1 << seq[0]) | (1 << (seq[0] ^ 1)));
        @(negedge CLOCK_50);
        btn_pulse = '0;
        check("lose_multi", lose, 1);
        @(negedge CLOCK_50);
        check("queue_drained", expq.size(), 0);

        // Game E: reset with start on the same edge during playback.
        do_start();
        n = 0;
        while (led == '0 && n < 20) begin
            @(negedge CLOCK_50);
            n++;
        end
        check("show_lit", (led != '0), 1);
        RESET = 1'b1;
        start = 1'b1;
        @(negedge CLOCK_50);
        check("mid_rst_led", led, 0);
        check("mid_rst_level", level, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_lfsr", dut.u_lfsr.q, SEED);
        RESET = 1'b0;
        start = 1'b0;
        expq.delete();
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge CLOCK_50);
            if (led != '0 || busy) seen = 1;
        end
        check("dark_after_reset", seen, 0);
        check("queue_empty", expq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
